// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, IDLE/FETCH control and a 2-entry
// {pc, instr} output FIFO presented to the decoder with a valid/ready handshake.
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [11:0] imem_addr,
  input  logic [18:0] imem_instr,
  input  logic        redir_valid,
  input  logic [11:0] redir_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] out_instr,
  output logic [11:0] out_pc,
  output logic [15:0] fetch_cnt
);

  localparam int unsigned PC_W    = 12;
  localparam int unsigned INSTR_W = 19;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [PC_W-1:0]      head_pc_q, head_pc_d;
  logic [INSTR_W-1:0]   head_instr_q, head_instr_d;
  logic [PC_W-1:0]      tail_pc_q, tail_pc_d;
  logic [INSTR_W-1:0]   tail_instr_q, tail_instr_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic                 pop_c;
  logic                 push_c;

  // Handshake and fetch qualification; valid_q mirrors cnt_q != 0.
  assign pop_c  = valid_q & out_ready;
  assign push_c = (state_q == FETCH) & fetch_en & ~redir_valid &
                  ((cnt_q != CNT_W'(2)) | pop_c);

  // Control FSM; a redirect holds the current state.
  always_comb begin
    state_d = state_q;
    if (!redir_valid) begin
      if (state_q == IDLE) begin
        if (fetch_en) state_d = FETCH;
      end else begin
        if (!fetch_en) state_d = IDLE;
      end
    end
  end

  // PC, fetch counter and FIFO next state. Slot "head" is always the oldest entry.
  always_comb begin
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (redir_valid) begin
      cnt_d = CNT_W'(0);
      pc_d  = redir_target;
    end else begin
      if (push_c) begin
        pc_d   = pc_q + PC_W'(1);
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
      case ({push_c, pop_c})
        2'b10: begin
          if (cnt_q == CNT_W'(0)) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_instr;
          end else begin
            tail_pc_d    = pc_q;
            tail_instr_d = imem_instr;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          cnt_d        = cnt_q - CNT_W'(1);
        end
        2'b11: begin
          if (cnt_q == CNT_W'(1)) begin
            head_pc_d    = pc_q;
            head_instr_d = imem_instr;
          end else begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = pc_q;
            tail_instr_d = imem_instr;
          end
        end
        default: begin
        end
      endcase
    end

    valid_d = (cnt_d != CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      cnt_q        <= CNT_W'(0);
      valid_q      <= 1'b0;
      head_pc_q    <= PC_W'(0);
      head_instr_q <= INSTR_W'(0);
      tail_pc_q    <= PC_W'(0);
      tail_instr_q <= INSTR_W'(0);
      fcnt_q       <= FCNT_W'(0);
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_pc    = head_pc_q;
  assign out_instr = head_instr_q;
  assign fetch_cnt = fcnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch behaviour.
module tb_fetch_unit;

  localparam logic [11:0] RST_PC = 12'd0;
  localparam logic [18:0] WORD2  = 19'b0000001101000101111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [11:0] imem_addr;
  logic [18:0] imem_instr;
  logic        redir_valid = 1'b0;
  logic [11:0] redir_target = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [18:0] out_instr;
  logic [11:0] out_pc;
  logic [15:0] fetch_cnt;

  logic [18:0] mem [4096];

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO as a queue of {pc, instr}, plus PC, fetching flag, counter.
  logic [30:0] mq[$];
  logic [11:0] m_pc;
  bit          m_fetch;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redir_valid (redir_valid),
    .redir_target(redir_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .fetch_cnt   (fetch_cnt)
  );

  task automatic model_reset();
    mq.delete();
    m_pc    = RST_PC;
    m_fetch = 1'b0;
    m_cnt   = 16'd0;
  endtask

  // Advance one rising edge and apply the same event to the model; returns at edge+1.
  task automatic tick();
    bit pop;
    bit push;
    pop  = (mq.size() != 0) && out_ready;
    push = m_fetch && fetch_en && !redir_valid && ((mq.size() < 2) || pop);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (redir_valid) begin
      mq.delete();
      m_pc = redir_target;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({m_pc, mem[m_pc]});
        m_pc  = m_pc + 12'd1;
        m_cnt = m_cnt + 16'd1;
      end
      m_fetch = fetch_en;
    end
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++;
    if (imem_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%0d want=%0d", imem_addr, RST_PC); end
    total++;
    if (out_pc !== 12'd0 || out_instr !== 19'd0) begin
      bad++; $display("FAIL reset_head got pc=%0d instr=%h want 0/0", out_pc, out_instr);
    end
    total++;
    if (fetch_cnt !== 16'd0) begin bad++; $display("FAIL reset_fcnt got=%0d want=0", fetch_cnt); end
  endtask

  task automatic test_stream();
    logic [11:0] exp_pc;
    exp_pc = 12'd0;
    rst = 1'b0;
    model_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first_edge got=%0b want=0", out_valid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        bad++; $display("FAIL stream_pc got v=%0b pc=%0d want v=1 pc=%0d", out_valid, out_pc, exp_pc);
      end
      if (exp_pc == 12'd2) begin
        total++;
        if (out_instr !== WORD2) begin bad++; $display("FAIL stream_word2 got=%b want=%b", out_instr, WORD2); end
      end
      exp_pc = exp_pc + 12'd1;
    end
    total++;
    if (fetch_cnt !== 16'(exp_pc)) begin bad++; $display("FAIL stream_fcnt got=%0d want=%0d", fetch_cnt, exp_pc); end
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    logic [18:0] held_instr;
    held       = out_pc;
    held_instr = out_instr;
    out_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_pc !== held || out_instr !== held_instr) begin
        bad++; $display("FAIL bp_stable got pc=%0d instr=%h want pc=%0d instr=%h", out_pc, out_instr, held, held_instr);
      end
    end
    total++;
    if (mq.size() != 2 || out_valid !== 1'b1 || imem_addr !== held + 12'd2) begin
      bad++; $display("FAIL bp_full got v=%0b addr=%0d want v=1 addr=%0d", out_valid, imem_addr, held + 12'd2);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_pc !== held) begin
        bad++; $display("FAIL bp_order got v=%0b pc=%0d want v=1 pc=%0d", out_valid, out_pc, held);
      end
      tick();
      held = held + 12'd1;
    end
  endtask

  task automatic test_redirect();
    logic [15:0] cnt_before;
    bit seen;
    out_ready = 1'b0;
    tick(); tick(); tick();
    cnt_before   = m_cnt;
    out_ready    = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 12'd25;
    tick();
    redir_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== 12'd25) begin
      bad++; $display("FAIL redir_flush got v=%0b addr=%0d want v=0 addr=25", out_valid, imem_addr);
    end
    total++;
    if (fetch_cnt !== cnt_before) begin bad++; $display("FAIL redir_fcnt got=%0d want=%0d", fetch_cnt, cnt_before); end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (!seen || out_pc !== 12'd25) begin
      bad++; $display("FAIL redir_next got v=%0b pc=%0d want v=1 pc=25", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] want [4];
    logic [11:0] got  [4];
    int n;
    want[0] = 12'd4094; want[1] = 12'd4095; want[2] = 12'd0; want[3] = 12'd1;
    n = 0;
    fetch_en     = 1'b1;
    out_ready    = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 12'd4094;
    tick();
    redir_valid = 1'b0;
    for (int i = 0; i < 12 && n < 4; i++) begin
      tick();
      if (out_valid) begin got[n] = out_pc; n++; end
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL wrap_timeout got=%0d entries want=4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got[i] !== want[i]) begin bad++; $display("FAIL wrap_seq[%0d] got=%0d want=%0d", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    int edges;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4 && !out_valid; i++) tick();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got v=%0b want=1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== RST_PC || fetch_cnt !== 16'd0) begin
      bad++; $display("FAIL arst_now got v=%0b addr=%0d fcnt=%0d want 0/%0d/0", out_valid, imem_addr, fetch_cnt, RST_PC);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    edges = 0;
    for (int i = 0; i < 6 && !out_valid; i++) begin
      tick();
      edges++;
    end
    total++;
    if (out_valid !== 1'b1 || edges != 2 || out_pc !== RST_PC) begin
      bad++; $display("FAIL arst_resume got v=%0b edges=%0d pc=%0d want v=1 edges=2 pc=%0d", out_valid, edges, out_pc, RST_PC);
    end
  endtask

  task automatic test_fetch_gate();
    logic [11:0] pc_hold;
    logic [15:0] cnt_hold;
    int pops;
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    tick(); tick(); tick();
    pc_hold  = m_pc;
    cnt_hold = m_cnt;
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) pops++;
      tick();
    end
    total++;
    if (pops != 2 || out_valid !== 1'b0) begin
      bad++; $display("FAIL gate_drain got pops=%0d v=%0b want pops=2 v=0", pops, out_valid);
    end
    total++;
    if (imem_addr !== pc_hold || fetch_cnt !== cnt_hold) begin
      bad++; $display("FAIL gate_hold got addr=%0d fcnt=%0d want addr=%0d fcnt=%0d", imem_addr, fetch_cnt, pc_hold, cnt_hold);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fetch_en     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      redir_valid  = ($urandom_range(0, 15) == 0);
      redir_target = 12'($urandom);
      tick();
      total++;
      if (out_valid !== (mq.size() != 0)) begin
        bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", i, out_valid, mq.size() != 0);
      end else if (mq.size() != 0 && {out_pc, out_instr} !== mq[0]) begin
        bad++; $display("FAIL rand_head cyc=%0d got pc=%0d instr=%h want pc=%0d instr=%h",
                        i, out_pc, out_instr, mq[0][30:19], mq[0][18:0]);
      end
      total++;
      if (imem_addr !== m_pc || fetch_cnt !== m_cnt) begin
        bad++; $display("FAIL rand_pc cyc=%0d got addr=%0d fcnt=%0d want addr=%0d fcnt=%0d",
                        i, imem_addr, fetch_cnt, m_pc, m_cnt);
      end
    end
    redir_valid = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 19'($urandom);
    mem[2] = WORD2;
    model_reset();
    #12;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_fetch_gate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
